// File: rtl/immed_pkg.sv
// immed_pkg: shared format-select encoding and default width for the immediate generator
package immed_pkg;
    typedef enum logic [2:0] {
        I_IMMED,
        S_IMMED,
        B_IMMED,
        U_IMMED,
        J_IMMED,
        Z_IMMED,
        SH_IMMED,
        BAD_IMMED
    } immed_src_e;
    localparam int XLEN_DEFAULT = 32;
endpackage

// File: rtl/immed_extract.sv
// immed_extract: combinational decode of one instruction word into its XLEN-wide immediate
module immed_extract import immed_pkg::*; #(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     inst,
    input  immed_src_e      src,
    output logic [XLEN-1:0] immed,
    output logic            illegal
);
    logic s;
    logic unused_opcode;
    assign s = inst[31];
    assign unused_opcode = ^inst[6:0];
    // select the format; the sign bit is folded into the replication so no zero-width repeat appears at XLEN=32
    always_comb begin
        immed = '0;
        illegal = (src == BAD_IMMED);
        case (src)
            I_IMMED:  immed = {{(XLEN-12){s}}, inst[31:20]};
            S_IMMED:  immed = {{(XLEN-12){s}}, inst[31:25], inst[11:7]};
            B_IMMED:  immed = {{(XLEN-12){s}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            U_IMMED:  immed = {{(XLEN-31){s}}, inst[30:12], 12'b0};
            J_IMMED:  immed = {{(XLEN-20){s}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            Z_IMMED:  immed = {{(XLEN-5){1'b0}}, inst[19:15]};
            SH_IMMED: immed = {{(XLEN-6){1'b0}}, (XLEN == 64) ? inst[25] : 1'b0, inst[24:20]};
            default:  immed = '0;
        endcase
    end
endmodule

// File: rtl/immed_gen_pipe.sv
// immed_gen_pipe: one-stage immediate generator with valid/ready on both sides and a skid entry
module immed_gen_pipe import immed_pkg::*; #(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  immed_src_e       immedSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  immed,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);
    logic [XLEN-1:0]  x_immed, m_immed, k_immed;
    logic             x_ill, m_ill, k_ill;
    logic [TAG_W-1:0] m_tag, k_tag;
    logic             m_valid, k_valid, acc, load_m;

    immed_extract #(.XLEN(XLEN)) u_extract (
        .inst    (inst),
        .src     (immedSrc),
        .immed   (x_immed),
        .illegal (x_ill)
    );

    assign in_ready  = ~k_valid;
    assign out_valid = m_valid;
    assign immed     = m_immed;
    assign out_tag   = m_tag;
    assign illegal   = m_ill;
    assign acc       = in_valid & in_ready;
    assign load_m    = ~m_valid | out_ready;

    // M refills from K first to keep order, else from the input; a beat arriving while M stalls parks in K
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            k_valid <= 1'b0;
            m_immed <= '0;
            m_tag   <= '0;
            m_ill   <= 1'b0;
            k_immed <= '0;
            k_tag   <= '0;
            k_ill   <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
            k_valid <= 1'b0;
        end else if (load_m) begin
            m_valid <= k_valid | acc;
            if (k_valid) begin
                m_immed <= k_immed;
                m_tag   <= k_tag;
                m_ill   <= k_ill;
                k_valid <= 1'b0;
            end else if (acc) begin
                m_immed <= x_immed;
                m_tag   <= in_tag;
                m_ill   <= x_ill;
            end
        end else if (acc) begin
            k_valid <= 1'b1;
            k_immed <= x_immed;
            k_tag   <= in_tag;
            k_ill   <= x_ill;
        end
    end
endmodule
